// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

  // Execute-stage operand forward selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Default multiply/divide unit latencies, in MDU cycles
  localparam int unsigned MULT_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF  = 32;
  localparam int unsigned CNT_W_DEF    = 6;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide unit sequencer: busy FSM, latency counter and start pulse.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_d,
  input  logic md_div_d,
  input  logic pipe_stall,   // load-use or branch stall; blocks issue
  output logic md_start_e,
  output logic md_busy_c,
  output logic cnt_zero_c
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic             issue;

  // Latency reload value for the instruction currently in D
  assign load_val = md_div_d ? DIV_LOAD : MULT_LOAD;

  // Issue is only possible when idle or on the final busy cycle, where the
  // MDU stall term is already zero, so only pipeline hazards can block it.
  assign issue = md_start_d && !pipe_stall && (state == MD_IDLE || cnt == '0);

  assign md_busy_c  = (state == MD_BUSY);
  assign cnt_zero_c = (cnt == '0);

  // Busy FSM with latency counter and registered start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MD_IDLE;
      cnt        <= '0;
      md_start_e <= 1'b0;
    end else begin
      md_start_e <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (issue) begin
            state      <= MD_BUSY;
            cnt        <= load_val;
            md_start_e <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (issue) begin
            cnt        <= load_val;
            md_start_e <= 1'b1;
          end else begin
            state <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Forwarding mux selects, load-use/branch/MDU stalls, and MDU issue sequencing.
// Optional HAZARD_PERF_EN adds saturating 32-bit stall performance counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MdStartD,
  input  logic       MdDivD,
  input  logic       MfHiLoD,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MdStartE,
`ifdef HAZARD_PERF_EN
  output logic [31:0] PerfStallCnt,
  output logic [31:0] PerfLwCnt,
  output logic [31:0] PerfMdCnt,
`endif
  output logic       MdBusy
);

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;
  logic md_cnt_zero;

  // Register-0 aware match helper: $zero never carries a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Operand forwarding selects for D compare and E ALU inputs
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && reg_match(WriteRegM, RsE))      ForwardAE = FWD_MEM;
    else if (RegWriteW && reg_match(WriteRegW, RsE)) ForwardAE = FWD_WB;
    if (RegWriteM && reg_match(WriteRegM, RtE))      ForwardBE = FWD_MEM;
    else if (RegWriteW && reg_match(WriteRegW, RtE)) ForwardBE = FWD_WB;
    ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
    ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);
  end

  // Stall sources; MDU stall releases on the final busy cycle
  always_comb begin
    lwstall = MemtoRegE && (reg_match(RtE, RsD) || reg_match(RtE, RtD));
    brstall = BranchD &&
              ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
               (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
    mdstall = MdBusy && !md_cnt_zero && (MdStartD || MfHiLoD);
    stall   = lwstall || brstall || mdstall;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  md_sequencer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_sequencer (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_d (MdStartD),
    .md_div_d   (MdDivD),
    .pipe_stall (lwstall || brstall),
    .md_start_e (MdStartE),
    .md_busy_c  (MdBusy),
    .cnt_zero_c (md_cnt_zero)
  );

`ifdef HAZARD_PERF_EN
  // Saturating stall event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PerfStallCnt <= '0;
      PerfLwCnt    <= '0;
      PerfMdCnt    <= '0;
    end else begin
      if (stall && (PerfStallCnt != 32'hFFFF_FFFF)) PerfStallCnt <= PerfStallCnt + 32'd1;
      if (lwstall && (PerfLwCnt != 32'hFFFF_FFFF))  PerfLwCnt    <= PerfLwCnt + 32'd1;
      if (mdstall && (PerfMdCnt != 32'hFFFF_FFFF))  PerfMdCnt    <= PerfMdCnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the decode-stage compare forwarding muxes and the execute-stage operand forwarding muxes.
- Detects load-use and branch-compare hazards and stalls F/D while flushing E.
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy FSM and latency counter; stalls D while MDU results are not yet available.

Parameters:
- MULT_LAT, 4, MDU cycles for mult/multu, from the first busy cycle to HI/LO valid.
- DIV_LAT, 32, MDU cycles for div/divu.
- CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, active low.
- RsD, RtD  in  5 each  source registers of the instruction in D.
- RsE, RtE  in  5 each  source registers of the instruction in E.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination registers in E/M/W.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  write enables in E/M/W.
- MemtoRegE, MemtoRegM  in  1 each  the instruction in E/M is a load.
- BranchD  in  1  a beq/bne is in D.
- MdStartD  in  1  a mult/div is in D.
- MdDivD  in  1  1 = div, 0 = mult; qualified by MdStartD.
- MfHiLoD  in  1  an mfhi/mflo is in D.
- ForwardAD, ForwardBD  out  1 each  select ALUOutM for the D compare operands.
- ForwardAE, ForwardBE  out  2 each  E operand select: 00 regfile, 01 ResultW, 10 ALUOutM.
- StallF, StallD  out  1 each  hold PC and the IF/ID register.
- FlushE  out  1  bubble into the ID/EX register.
- MdStartE  out  1  registered one-cycle start pulse to the MDU.
- MdBusy  out  1  MDU in progress.

Behaviour:
- Register 0 never matches in any comparison below.

Forwarding (combinational):
- ForwardAE = 10 if RegWriteM && WriteRegM==RsE; else 01 if RegWriteW && WriteRegW==RsE; else 00.
- ForwardBE follows the same rule with RtE.
- ForwardAD = RegWriteM && WriteRegM==RsD. ForwardBD uses the same rule with RtD.

Stall terms (combinational):
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- mdstall = MdBusy && cnt!=0 && (MdStartD || MfHiLoD).
- stall = lwstall | brstall | mdstall.
- StallF = StallD = FlushE = stall.

MDU FSM (states IDLE, BUSY):
- IDLE: if MdStartD && !stall, go to BUSY next edge. Load cnt = (MdDivD ? DIV_LAT : MULT_LAT) - 1. Assert MdStartE for exactly that first BUSY cycle.
- BUSY, cnt!=0: decrement cnt each cycle.
- BUSY, cnt==0 (last cycle; HI/LO valid at the closing edge):
  - With MdStartD && !lwstall && !brstall: reload cnt and pulse MdStartE again (back-to-back issue, no bubble).
  - Otherwise go to IDLE.
- MfHiLoD is not stalled in the cnt==0 cycle.
- MdBusy = (state==BUSY).
- A stalled MdStartD stays in D and is re-evaluated every cycle. It is never accepted twice, because D is held while stall=1.

Reset (asynchronous, active low):
- state=IDLE, cnt=0, MdStartE=0, so MdBusy=0.
- Combinational outputs follow their inputs.
- Reset asserted mid-operation aborts the MDU sequence immediately; no pulse is emitted after release.
- Latency: forwarding and stall outputs are zero-cycle. MdStartE lands 1 cycle after acceptance.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs PerfStallCnt, PerfLwCnt, PerfMdCnt (32 bits each).
  - PerfStallCnt increments on every stall cycle.
  - PerfLwCnt increments when lwstall=1.
  - PerfMdCnt increments when mdstall=1.
  - All three counters saturate at 0xFFFFFFFF and reset to 0.
- HAZARD_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - md_state_t enum {MD_IDLE, MD_BUSY}.
  - Default MULT_LAT and DIV_LAT.
- Sub-module md_sequencer (FSM + cnt + MdStartE) is natural.
- Forwarding and stall logic stay in hazard_ctrl.

Test Plan:
1. Forwarding: RsE=5, RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RsE=0 -> ForwardAE=00.
2. Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle. Next cycle MemtoRegE=0 -> all 0.
3. Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 -> stall=1. Next cycle RegWriteM=1, WriteRegM=3, MemtoRegM=0 -> stall=0, ForwardAD=1.
4. MDU: MdStartD=1, MdDivD=0 accepted -> MdStartE=1 for one cycle, MdBusy=1 for 4 cycles. mflo in D during cycles 1-3 -> stall=1. In cycle 4 -> stall=0.
5. Back-to-back: a div (cnt loaded 31) followed by a mult held in D -> mult stalled 31 cycles, accepted on the cnt==0 cycle -> MdStartE pulses again with no IDLE gap.
6. Reset: assert rst_n=0 at cnt=10 of a div -> MdBusy=0 and MdStartE=0 immediately. After release, no stall appears for mflo.
